// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: waits for a live reference, pulses PLL reset, qualifies lock,
// and only then releases the reset of the logic clocked by the PLL output.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int REF_TIMEOUT        = 64,
   parameter int RETRY_LIMIT        = 7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_lock,
   input  logic       ref_toggle,
   input  logic       restart,
   output logic       pll_reset,
   output logic       sys_reset_n,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count
);

   localparam int RST_W    = $clog2(PLL_RST_CYCLES + 1);
   localparam int LOCK_W   = $clog2(LOCK_TIMEOUT + 1);
   localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int REF_W    = $clog2(REF_TIMEOUT + 1);

   localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
   localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_TIMEOUT - 1);
   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [REF_W-1:0]    REF_MAX     = REF_W'(REF_TIMEOUT);
   localparam logic [3:0]          RETRY_MAX   = 4'(RETRY_LIMIT);

   typedef enum logic [2:0] {
      WAIT_REF,
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } state_t;

   state_t state;
   state_t next_state;

   logic [1:0]          rst_sync;
   logic                active;
   logic                lock_meta;
   logic                lock_sync;
   logic                ref_meta;
   logic                ref_sync;
   logic                ref_prev;
   logic                ref_edge;
   logic                ref_seen;
   logic                ref_ok;
   logic [REF_W-1:0]    ref_cnt;
   logic [RST_W-1:0]    rst_cnt;
   logic [LOCK_W-1:0]   lock_cnt;
   logic [STABLE_W-1:0] stable_cnt;
   logic [3:0]          retry_next;
   logic [3:0]          retry_inc;

   // Reset release is synchronized so the FSM leaves reset cleanly two edges after reset_n rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign active = rst_sync[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
         ref_meta  <= 1'b0;
         ref_sync  <= 1'b0;
         ref_prev  <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_sync <= lock_meta;
         ref_meta  <= ref_toggle;
         ref_sync  <= ref_meta;
         ref_prev  <= ref_sync;
      end
   end

   assign ref_edge = ref_sync ^ ref_prev;

   // ref_seen keeps a quiet reference after reset from looking alive before its first edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ref_cnt  <= '0;
         ref_seen <= 1'b0;
      end else begin
         if (ref_edge) begin
            ref_seen <= 1'b1;
         end
         if ((active && restart) || ref_edge) begin
            ref_cnt <= '0;
         end else if (ref_cnt != REF_MAX) begin
            ref_cnt <= ref_cnt + REF_W'(1);
         end
      end
   end

   assign ref_ok    = ref_seen && (ref_cnt < REF_MAX);
   assign retry_inc = retry_count + 4'd1;

   always_comb begin
      next_state = state;
      retry_next = retry_count;
      if (!active) begin
         next_state = state;
      end else if (restart) begin
         next_state = WAIT_REF;
         retry_next = 4'd0;
      end else begin
         case (state)
            WAIT_REF: begin
               if (ref_ok) next_state = PLL_RST;
            end
            PLL_RST: begin
               if (!ref_ok) next_state = WAIT_REF;
               else if (rst_cnt == RST_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (!ref_ok) begin
                  next_state = WAIT_REF;
               end else if (lock_sync) begin
                  next_state = STABLE;
               end else if (lock_cnt == LOCK_LAST) begin
                  retry_next = retry_inc;
                  next_state = (retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
               end
            end
            STABLE: begin
               if (!ref_ok) begin
                  next_state = WAIT_REF;
               end else if (!lock_sync) begin
                  next_state = WAIT_LOCK;
               end else if (stable_cnt == STABLE_LAST) begin
                  next_state = RUN;
                  retry_next = 4'd0;
               end
            end
            RUN: begin
               if (!lock_sync || !ref_ok) next_state = WAIT_REF;
            end
            FAULT: begin
               next_state = FAULT;
            end
            default: begin
               next_state = WAIT_REF;
            end
         endcase
      end
   end

   // Every state change zeroes the phase counters, so each one only ever counts inside its own state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_cnt    <= '0;
         lock_cnt   <= '0;
         stable_cnt <= '0;
      end else if (active) begin
         if (restart || (next_state != state)) begin
            rst_cnt    <= '0;
            lock_cnt   <= '0;
            stable_cnt <= '0;
         end else begin
            case (state)
               PLL_RST:   rst_cnt    <= rst_cnt + RST_W'(1);
               WAIT_LOCK: lock_cnt   <= lock_cnt + LOCK_W'(1);
               STABLE:    stable_cnt <= stable_cnt + STABLE_W'(1);
               default:   ;
            endcase
         end
      end
   end

   // Outputs are decoded from next_state so they switch on the same edge as the state itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= WAIT_REF;
         retry_count <= 4'd0;
         pll_reset   <= 1'b1;
         sys_reset_n <= 1'b0;
         ready       <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= next_state;
         retry_count <= retry_next;
         pll_reset   <= (next_state == WAIT_REF) || (next_state == PLL_RST) || (next_state == FAULT);
         sys_reset_n <= (next_state == RUN);
         ready       <= (next_state == RUN);
         fault       <= (next_state == FAULT);
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a table of timed checkpoints, directed corner-case
// sequences, and random stimulus compared every cycle against a behavioural model.
module tb_pll_reset_sequencer;

   localparam int PRC = 4;
   localparam int LT  = 32;
   localparam int LSC = 8;
   localparam int RT  = 16;
   localparam int RL  = 3;

   localparam int M_WREF  = 0;
   localparam int M_PRST  = 1;
   localparam int M_WLOCK = 2;
   localparam int M_STAB  = 3;
   localparam int M_RUN   = 4;
   localparam int M_FAULT = 5;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_lock = 1'b0;
   logic       ref_toggle = 1'b0;
   logic       restart = 1'b0;
   logic       pll_reset;
   logic       sys_reset_n;
   logic       ready;
   logic       fault;
   logic [3:0] retry_count;

   int total = 0;
   int bad = 0;
   int cur_tick = 0;
   bit ref_run = 1'b0;
   bit rand_period = 1'b0;
   int ref_period = 3;
   int ref_phase = 0;
   int last_toggle = 0;

   int m_phase, m_age, m_retry, m_since, m_rel;
   bit m_seen;
   bit lock_hist[$];
   bit ref_hist[$];

   typedef struct {
      int tick;
      bit rst_pulse;
      bit exp_pll_reset;
      bit exp_sys_reset_n;
      bit exp_ready;
      bit exp_fault;
      int exp_retry;
   } vec_t;

   vec_t vecs[$];

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(PRC),
      .LOCK_TIMEOUT(LT),
      .LOCK_STABLE_CYCLES(LSC),
      .REF_TIMEOUT(RT),
      .RETRY_LIMIT(RL)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .pll_lock(pll_lock),
      .ref_toggle(ref_toggle),
      .restart(restart),
      .pll_reset(pll_reset),
      .sys_reset_n(sys_reset_n),
      .ready(ready),
      .fault(fault),
      .retry_count(retry_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] dutOut();
      return {pll_reset, sys_reset_n, ready, fault, retry_count};
   endfunction

   // Model outputs follow directly from the phase it is in.
   function automatic logic [7:0] modelOut();
      logic [7:0] v;
      v[7]   = (m_phase == M_WREF) || (m_phase == M_PRST) || (m_phase == M_FAULT);
      v[6]   = (m_phase == M_RUN);
      v[5]   = (m_phase == M_RUN);
      v[4]   = (m_phase == M_FAULT);
      v[3:0] = 4'(m_retry);
      return v;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s at tick %0d: got 0x%0h, expected 0x%0h", name, cur_tick, actual, expected);
      end
   endtask

   task automatic modelReset();
      m_phase = M_WREF;
      m_age = 0;
      m_retry = 0;
      m_since = 0;
      m_seen = 1'b0;
      m_rel = 0;
      lock_hist = '{1'b0, 1'b0};
      ref_hist = '{1'b0, 1'b0, 1'b0};
   endtask

   // One clock edge of the model; m_age is simply the time spent in the current phase.
   task automatic modelEdge(input bit lock_in, input bit ref_in, input bit restart_in);
      bit act, lk, rok, redge;
      int np;
      act   = (m_rel >= 2);
      lk    = lock_hist[1];
      rok   = m_seen && (m_since < RT);
      redge = (ref_hist[1] != ref_hist[2]);
      np    = m_phase;
      if (act) begin
         if (restart_in) begin
            np = M_WREF;
            m_retry = 0;
         end else begin
            case (m_phase)
               M_WREF:  if (rok) np = M_PRST;
               M_PRST:  if (!rok) np = M_WREF; else if (m_age == PRC - 1) np = M_WLOCK;
               M_WLOCK: begin
                  if (!rok) np = M_WREF;
                  else if (lk) np = M_STAB;
                  else if (m_age == LT - 1) begin
                     m_retry++;
                     np = (m_retry == RL) ? M_FAULT : M_PRST;
                  end
               end
               M_STAB: begin
                  if (!rok) np = M_WREF;
                  else if (!lk) np = M_WLOCK;
                  else if (m_age == LSC - 1) begin
                     np = M_RUN;
                     m_retry = 0;
                  end
               end
               M_RUN:   if (!lk || !rok) np = M_WREF;
               default: ;
            endcase
         end
         m_age = (restart_in || np != m_phase) ? 0 : m_age + 1;
         m_phase = np;
      end
      if (act && restart_in) m_since = 0;
      else if (redge) m_since = 0;
      else if (m_since < RT) m_since++;
      if (redge) m_seen = 1'b1;
      lock_hist.push_front(lock_in);
      void'(lock_hist.pop_back());
      ref_hist.push_front(ref_in);
      void'(ref_hist.pop_back());
      if (m_rel < 2) m_rel++;
   endtask

   task automatic applyStimulus();
      bit l, r, s;
      l = pll_lock;
      r = ref_toggle;
      s = restart;
      @(posedge clk);
      modelEdge(l, r, s);
      #1;
      cur_tick++;
      checkOutput("model", dutOut(), modelOut());
      if (ref_run) begin
         ref_phase++;
         if (ref_phase >= ref_period) begin
            ref_toggle = ~ref_toggle;
            ref_phase = 0;
            last_toggle = cur_tick;
            if (rand_period) ref_period = $urandom_range(1, 5);
         end
      end
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      pll_lock = 1'b0;
      restart = 1'b0;
      ref_toggle = 1'b0;
      ref_phase = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state", dutOut(), 8'h80);
      modelReset();
      reset_n = 1'b1;
      cur_tick = 0;
   endtask

   initial begin
      int n;
      int p;
      int x;

      vecs.push_back('{2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
      vecs.push_back('{10,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
      vecs.push_back('{11,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
      vecs.push_back('{42,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
      vecs.push_back('{43,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{46,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{47,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{78,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{79,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2});
      vecs.push_back('{114, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2});
      vecs.push_back('{115, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3});
      vecs.push_back('{130, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3});
      vecs.push_back('{131, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0});
      vecs.push_back('{135, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
      vecs.push_back('{136, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});

      // Lock never arrives: three timeouts, fault, then a restart pulse.
      ref_run = 1'b1;
      ref_period = 3;
      rand_period = 1'b0;
      doReset();
      for (int i = 0; i < vecs.size(); i++) begin
         while (cur_tick < vecs[i].tick - 1) applyStimulus();
         restart = vecs[i].rst_pulse;
         applyStimulus();
         restart = 1'b0;
         checkOutput($sformatf("vec%0d", i), dutOut(),
                     {vecs[i].exp_pll_reset, vecs[i].exp_sys_reset_n, vecs[i].exp_ready,
                      vecs[i].exp_fault, 4'(vecs[i].exp_retry)});
      end

      // Normal bring-up with lock 10 cycles after PLL reset release.
      doReset();
      n = 0;
      while (pll_reset && n < 60) begin applyStimulus(); n++; end
      checkOutput("pll_reset_fall_tick", cur_tick, 11);
      repeat (10) applyStimulus();
      pll_lock = 1'b1;
      n = 0;
      while (!ready && n < 40) begin applyStimulus(); n++; end
      checkOutput("lock_to_ready", n, 11);
      checkOutput("sys_reset_n_with_ready", sys_reset_n, 1);

      // Reference freezes while running, then resumes.
      n = 0;
      while (last_toggle != cur_tick && n < 10) begin applyStimulus(); n++; end
      ref_run = 1'b0;
      x = last_toggle;
      n = 0;
      while (sys_reset_n && n < 40) begin applyStimulus(); n++; end
      checkOutput("ref_loss_latency", cur_tick - x, 20);
      checkOutput("ready_after_ref_loss", ready, 0);
      ref_run = 1'b1;
      ref_phase = 0;
      n = 0;
      while (!ready && n < 100) begin applyStimulus(); n++; end
      checkOutput("resume_ready", ready, 1);

      // Lock loss while running, then a one-cycle lock glitch in STABLE.
      pll_lock = 1'b0;
      n = 0;
      while (sys_reset_n && n < 10) begin applyStimulus(); n++; end
      checkOutput("lock_loss_latency", n, 3);
      n = 0;
      while (pll_reset && n < 40) begin applyStimulus(); n++; end
      checkOutput("relock_pll_reset_low", pll_reset, 0);
      repeat (2) applyStimulus();
      pll_lock = 1'b1;
      p = cur_tick;
      repeat (6) applyStimulus();
      pll_lock = 1'b0;
      applyStimulus();
      pll_lock = 1'b1;
      n = 0;
      while (!ready && n < 40) begin applyStimulus(); n++; end
      checkOutput("glitch_lock_to_ready", cur_tick - p, 18);
      checkOutput("glitch_retry_count", retry_count, 0);

      // Asynchronous reset in the middle of STABLE.
      pll_lock = 1'b0;
      repeat (4) applyStimulus();
      n = 0;
      while (pll_reset && n < 20) begin applyStimulus(); n++; end
      pll_lock = 1'b1;
      repeat (6) applyStimulus();
      checkOutput("pre_reset_outputs", dutOut(), 8'h00);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset", dutOut(), 8'h80);
      doReset();

      // Random traffic against the model.
      rand_period = 1'b1;
      ref_run = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
         if ($urandom_range(0, 149) == 0) begin
            ref_run = ~ref_run;
            ref_phase = 0;
         end
         restart = ($urandom_range(0, 299) == 0);
         applyStimulus();
      end
      restart = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
